// File: rtl/fetch_queue_ctrl.sv
// Instruction-fetch sequencer: issues word-aligned imem requests, queues returned
// words with their PCs for the realigner, and flushes/restarts on redirect.
module fetch_queue_ctrl #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_fw_valid,
    output logic [31:0] o_fw_instr,
    output logic [63:0] o_fw_pc,
    output logic        o_fw_half,
    input  logic        i_fw_consume
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];
    localparam logic [CW-1:0] MAX_C   = MAX_OUTST[CW-1:0];

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   fetch_addr_q, fetch_addr_d;
    logic          half_pend_q, half_pend_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [63:0]   fifo_pc_q    [DEPTH];
    logic [63:0]   fifo_pc_d    [DEPTH];
    logic          fifo_half_q  [DEPTH];
    logic          fifo_half_d  [DEPTH];

    logic          rvalid_eff;
    logic [CW:0]   credit;
    logic          req;
    logic          accept;
    logic          push;
    logic          pop;

    // Each outstanding request holds a reserved FIFO slot, so a response can always be stored.
    always_comb begin
        rvalid_eff = i_imem_rvalid && (outst_q != '0);
        credit     = {1'b0, cnt_q} + {1'b0, outst_q};
        req        = (state_q != BOOT) && !i_redirect
                     && (credit < DEPTH_C) && (outst_q < MAX_C);
        accept     = req && i_imem_gnt;
        push       = rvalid_eff && (drop_q == '0) && !i_redirect;
        pop        = (cnt_q != '0) && i_fw_consume && !i_redirect;
    end

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_addr_q;
    assign o_fw_valid  = (cnt_q != '0);
    assign o_fw_instr  = fifo_instr_q[rd_ptr_q];
    assign o_fw_pc     = fifo_pc_q[rd_ptr_q];
    assign o_fw_half   = o_fw_valid && fifo_half_q[rd_ptr_q];

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        if (accept) begin
            fetch_addr_d = fetch_addr_q + 64'd4;
            outst_d      = outst_d + CW'(1);
        end
        if (rvalid_eff) begin
            outst_d = outst_d - CW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (i_redirect) begin
            drop_d       = outst_q - (rvalid_eff ? CW'(1) : CW'(0));
            fetch_addr_d = i_redirect_pc & ~64'h3;
        end
    end

    // The first word pushed after a restart carries the full target PC, later ones are word-aligned.
    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_half_d  = fifo_half_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        half_pend_d  = half_pend_q;
        resp_pc_d    = resp_pc_q;
        if (push) begin
            fifo_instr_d[wr_ptr_q] = i_imem_rdata;
            fifo_pc_d[wr_ptr_q]    = resp_pc_q;
            fifo_half_d[wr_ptr_q]  = half_pend_q;
            wr_ptr_d               = wr_ptr_q + PW'(1);
            cnt_d                  = cnt_d + CW'(1);
            half_pend_d            = 1'b0;
            resp_pc_d              = {resp_pc_q[63:2], 2'b00} + 64'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = cnt_d - CW'(1);
        end
        if (i_redirect) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            half_pend_d = i_redirect_pc[1];
            resp_pc_d   = i_redirect_pc & ~64'h1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            DRAIN:   state_d = (drop_d == '0) ? RUN : DRAIN;
            default: state_d = BOOT;
        endcase
        if (i_redirect) begin
            state_d = (drop_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            fetch_addr_q <= {RESET_PC[63:2], 2'b00};
            half_pend_q  <= RESET_PC[1];
            resp_pc_q    <= {RESET_PC[63:1], 1'b0};
            outst_q      <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            half_pend_q  <= half_pend_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
        fifo_half_q  <= fifo_half_d;
    end

endmodule
